// File: rtl/sha1_ctrl_wb.sv
// Drives the SHA-1 coprocessor for one EX request, then writes the 160-bit digest to memory
// as five 32-bit words with H0 at the lowest address. The pipeline is stalled while this runs.
//
// Handshake rules: req_i is a one-cycle pulse and is taken only in IDLE. start_o stays high
// through RUN and drops in the cycle ready_i is seen. Each memory word is a valid/ready pair:
// mem_req_o/mem_addr_o/mem_data_o hold steady until mem_gnt_i is sampled high, and the next
// word follows on the very next cycle. done_o and err_o are single-cycle pulses.
module sha1_ctrl_wb #(
    parameter int TIMEOUT_CYCLES = 128,
    parameter int ADDR_STEP      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_i,
    input  logic [31:0]  para_i,
    input  logic [31:0]  addr_i,
    output logic         start_o,
    output logic [31:0]  para_o,
    output logic [31:0]  sha1_addr_o,
    input  logic [159:0] result_i,
    input  logic         ready_i,
    input  logic         busy_i,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [31:0]  mem_data_o,
    input  logic         mem_gnt_i,
    output logic         stall_o,
    output logic         done_o,
    output logic         err_o,
    output logic [1:0]   dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    para_q, addr_q;
    logic [159:0]   buf_q;
    logic [2:0]     k_q;
    logic [TW-1:0]  timer_q;
    logic           err_q;

    logic accept, misaligned, timeout;

    assign accept     = (state_q == S_IDLE) && req_i && (addr_i[1:0] == 2'b00);
    assign misaligned = (state_q == S_IDLE) && req_i && (addr_i[1:0] != 2'b00);
    assign timeout    = (state_q == S_RUN) && !ready_i &&
                        (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN: begin
                if (ready_i)      state_d = S_WRITE;
                else if (timeout) state_d = S_IDLE;
            end
            S_WRITE: if (mem_gnt_i && (k_q == 3'd4)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_o    = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = 32'd0;
        mem_data_o = 32'd0;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE: stall_o = req_i;
            S_RUN: begin
                start_o = !ready_i;
                stall_o = 1'b1;
            end
            S_WRITE: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = addr_q + 32'(ADDR_STEP) * 32'(k_q);
                // The buffer shifts left on each grant, so the current word is always on top.
                mem_data_o = buf_q[159:128];
                stall_o    = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign para_o      = para_q;
    assign sha1_addr_o = addr_q;
    assign err_o       = err_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            para_q  <= 32'd0;
            addr_q  <= 32'd0;
            buf_q   <= 160'd0;
            k_q     <= 3'd0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= misaligned || timeout;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        para_q  <= para_i;
                        addr_q  <= addr_i;
                        timer_q <= '0;
                    end
                end
                S_RUN: begin
                    if (ready_i) begin
                        buf_q <= result_i;
                        k_q   <= 3'd0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_gnt_i) begin
                        k_q   <= k_q + 3'd1;
                        buf_q <= {buf_q[127:0], 32'd0};
                    end
                end
                default: ;
            endcase
        end
    end

    // The core must have finished computing by the time its digest is being written out.
    write_while_busy_a : assert property (@(posedge clk) disable iff (rst)
        (state_q == S_WRITE) |-> !busy_i);

endmodule

// File: tb/tb_sha1_ctrl_wb.sv
// Randomized bench for sha1_ctrl_wb: models the core and memory, predicts the digest writes
// and done/err events from the request alone, and checks them from a separate monitor.
module tb_sha1_ctrl_wb;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_i;
    logic [31:0]  para_i, addr_i;
    logic         start_o;
    logic [31:0]  para_o, sha1_addr_o;
    logic [159:0] result_i;
    logic         ready_i, busy_i;
    logic         mem_req_o, mem_we_o;
    logic [31:0]  mem_addr_o, mem_data_o;
    logic         mem_gnt_i;
    logic         stall_o, done_o, err_o;
    logic [1:0]   dbg_state;

    localparam logic [7:0] EV_DONE = 8'd1;
    localparam logic [7:0] EV_ERR  = 8'd2;

    logic [63:0]  exp_q[$];
    logic [7:0]   ev_q[$];
    int           checks = 0;
    int           errors = 0;

    int           core_lat = 0;
    int           gap_min  = 0;
    int           gap_max  = 0;
    logic [159:0] cur_digest = 160'd0;

    sha1_ctrl_wb #(.TIMEOUT_CYCLES(128), .ADDR_STEP(4)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .para_i(para_i), .addr_i(addr_i),
        .start_o(start_o), .para_o(para_o), .sha1_addr_o(sha1_addr_o),
        .result_i(result_i), .ready_i(ready_i), .busy_i(busy_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_gnt_i(mem_gnt_i),
        .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- core model ----------------
    initial begin
        int run_cnt;
        run_cnt  = 0;
        ready_i  = 1'b0;
        busy_i   = 1'b0;
        result_i = 160'd0;
        forever begin
            @(negedge clk);
            if (ready_i) begin
                ready_i = 1'b0;
                busy_i  = 1'b0;
                run_cnt = 0;
            end else if (rst || !start_o) begin
                busy_i  = 1'b0;
                run_cnt = 0;
            end else begin
                run_cnt++;
                busy_i = 1'b1;
                if (core_lat != 0 && run_cnt >= core_lat) begin
                    ready_i  = 1'b1;
                    result_i = cur_digest;
                    #1;
                    check("start_low_on_ready", 64'(start_o), 64'd0);
                end
            end
        end
    end

    // ---------------- memory grant model ----------------
    initial begin
        int wcnt, wait_n;
        wcnt      = 0;
        wait_n    = 0;
        mem_gnt_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req_o) begin
                mem_gnt_i = 1'b0;
                wcnt      = 0;
                wait_n    = $urandom_range(gap_max, gap_min);
            end else if (wcnt >= wait_n) begin
                mem_gnt_i = 1'b1;
                wcnt      = 0;
                wait_n    = $urandom_range(gap_max, gap_min);
            end else begin
                mem_gnt_i = 1'b0;
                wcnt++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        pend;
        logic [31:0] pa, pd;
        logic [63:0] e;
        logic [7:0]  ev;
        pend = 1'b0;
        pa   = 32'd0;
        pd   = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend && mem_req_o) begin
                    check("addr_stable_while_ungranted", 64'(mem_addr_o), 64'(pa));
                    check("data_stable_while_ungranted", 64'(mem_data_o), 64'(pd));
                end
                if (mem_req_o) begin
                    check("we_follows_req", 64'(mem_we_o), 64'd1);
                    if (mem_gnt_i) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write: got %h@%h expected no write",
                                     mem_data_o, mem_addr_o);
                        end else begin
                            e = exp_q.pop_front();
                            if ({mem_addr_o, mem_data_o} !== e) begin
                                errors++;
                                $display("FAIL write: got %h@%h expected %h@%h",
                                         mem_data_o, mem_addr_o, e[31:0], e[63:32]);
                            end
                        end
                    end
                end
                pend = mem_req_o && !mem_gnt_i;
                pa   = mem_addr_o;
                pd   = mem_data_o;
                if (done_o || err_o) begin
                    check("stall_low_on_event", 64'(stall_o), 64'd0);
                    check("single_event", 64'(done_o && err_o), 64'd0);
                    ev = done_o ? EV_DONE : EV_ERR;
                    checks++;
                    if (ev_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: got %0d expected none", ev);
                    end else begin
                        e[7:0] = ev_q.pop_front();
                        if (ev !== e[7:0]) begin
                            errors++;
                            $display("FAIL event_kind: got %0d expected %0d", ev, e[7:0]);
                        end
                    end
                    if (done_o)
                        check("all_words_before_done", 64'(exp_q.size()), 64'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] para, input logic [31:0] addr, input int lat,
                         input int gmin, input int gmax, input logic [159:0] digest,
                         input bit push);
        bit ok;
        ok = (addr[1:0] == 2'b00);
        @(negedge clk);
        core_lat   = lat;
        gap_min    = gmin;
        gap_max    = gmax;
        cur_digest = digest;
        req_i      = 1'b1;
        para_i     = para;
        addr_i     = addr;
        if (push) begin
            if (!ok || lat == 0) begin
                ev_q.push_back(EV_ERR);
            end else begin
                for (int k = 0; k < 5; k++)
                    exp_q.push_back({addr + 32'(4 * k), digest[159 - 32 * k -: 32]});
                ev_q.push_back(EV_DONE);
            end
        end
        #1;
        check("stall_in_req_cycle", 64'(stall_o), 64'd1);
        @(negedge clk);
        req_i  = 1'b0;
        para_i = $urandom;
        addr_i = $urandom;
        #1;
        if (ok) begin
            check("para_latched", 64'(para_o), 64'(para));
            check("addr_latched", 64'(sha1_addr_o), 64'(addr));
        end else begin
            check("misaligned_no_start", 64'(start_o), 64'd0);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #3;
            if (ev_q.size() == 0 && dbg_state == 2'd0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got busy expected idle within 3000 cycles", name);
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_start"}, 64'(start_o), 64'd0);
        check({name, "_stall"}, 64'(stall_o), 64'd0);
        check({name, "_mem_req"}, 64'({mem_req_o, mem_we_o}), 64'd0);
        check({name, "_mem_bus"}, {mem_addr_o, mem_data_o}, 64'd0);
        check({name, "_done_err"}, 64'({done_o, err_o}), 64'd0);
        check({name, "_latches"}, {para_o, sha1_addr_o}, 64'd0);
        check({name, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [159:0] dg;
        logic [31:0]  a;
        int           hi;
        bit           found;
        rst    = 1'b1;
        req_i  = 1'b0;
        para_i = 32'd0;
        addr_i = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Known "abcd" digest, continuous grant then 3-cycle grant gaps.
        dg = 160'h81fe8bfe87576c3ecb22426f8e57847382917acf;
        issue(32'h61626364, 32'h100, 83, 0, 0, dg, 1'b1);
        wait_idle("abcd");
        check("stall_low_after_done", 64'(stall_o), 64'd0);
        issue(32'h61626364, 32'h100, 83, 3, 3, dg, 1'b1);
        wait_idle("abcd_gaps");

        // Address wrap at the top of the address space.
        issue($urandom, 32'hFFFFFFF8, 40, 0, 2,
              {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
        wait_idle("wrap");

        // Misaligned destination.
        issue($urandom, 32'h102, 30, 0, 0, dg, 1'b1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("misaligned_quiet", 64'({start_o, mem_req_o, stall_o}), 64'd0);
        end
        wait_idle("misaligned");

        // Core never answers: timeout, then a normal request.
        issue($urandom, 32'h200, 0, 0, 0, dg, 1'b1);
        hi = int'(start_o);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (start_o) hi++;
            else break;
        end
        check("timeout_run_cycles", 64'(hi), 64'd128);
        wait_idle("timeout");
        issue($urandom, 32'h300, 83, 0, 1,
              {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
        wait_idle("after_timeout");

        // Reset in RUN at cycle 40, with extra requests that must be ignored.
        issue(32'hA5A5_0001, 32'h400, 100, 0, 0, dg, 1'b0);
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            req_i  = (c % 10 == 0);
            para_i = $urandom;
            addr_i = $urandom & 32'hFFFF_FFFC;
        end
        #1;
        check("extra_req_ignored", {para_o, sha1_addr_o}, {32'hA5A5_0001, 32'h400});
        req_i = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("rst_in_run");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset in WRITE after two grants.
        issue($urandom, 32'h500, 20, 0, 0,
              {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("two_grants_seen", 64'(found), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        ev_q.delete();
        @(negedge clk);
        #1;
        check_all_zero("rst_in_write");
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("no_write_after_reset", 64'(mem_req_o), 64'd0);
        end

        // Random traffic.
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            if ($urandom_range(7, 0) != 0) a[1:0] = 2'b00;
            issue($urandom, a, $urandom_range(100, 1), 0, $urandom_range(3, 0),
                  {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
            wait_idle("random");
        end

        repeat (3) @(negedge clk);
        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        check("event_queue_drained", 64'(ev_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
